// File: rtl/sap_controller_sequencer.sv
// SAP-1 style control sequencer: T1..T6 ring counter plus opcode decode into the control word.
// Optional `define SEQ_EARLY_RETIRE_EN returns to T1 right after an instruction's last active micro-op.
module sap_controller_sequencer #(
  parameter int OP_W  = 4,
  parameter int NUM_T = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OP_W-1:0]  instr_op,
  input  logic             carry_flag,
  input  logic             zero_flag,
  output logic             pc_clr_n,
  output logic             cp,
  output logic             ep,
  output logic             lp,
  output logic             lm,
  output logic             ce,
  output logic             li,
  output logic             ei,
  output logic             la,
  output logic             ea,
  output logic             lb,
  output logic             su,
  output logic             eu,
  output logic             lo,
  output logic             hlt,
  output logic [NUM_T-1:0] t_state
);

  if (NUM_T != 6) begin : g_num_t_check
    $error("sap_controller_sequencer: NUM_T must be 6");
  end

  typedef enum logic [2:0] {
    S_INIT, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef struct packed {
    logic cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo;
  } ctrl_t;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  state_t state, state_nxt;
  ctrl_t  micro, ctrl;
  logic   retire;
  logic   uses_alu_or_mem;

  // NOTE: state uses non-blocking assignment with clr in the sensitivity list, so reset
  // takes effect at once rather than waiting for the next clock edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_INIT;
    else     state <= state_nxt;
  end

  assign uses_alu_or_mem = (instr_op == OP_LDA) || (instr_op == OP_ADD) || (instr_op == OP_SUB);

`ifdef SEQ_EARLY_RETIRE_EN
  // Jumps, OUT and NOPs finish in T4; LDA has nothing to do in T6.
  assign retire = ((state == S_T4) && !uses_alu_or_mem) ||
                  ((state == S_T5) && (instr_op == OP_LDA));
`else
  assign retire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: state_nxt = S_T1;
      S_HALT: state_nxt = S_HALT;
      default: begin
        if (run) begin
          if ((state == S_T4) && (instr_op == OP_HLT)) state_nxt = S_HALT;
          else if (retire || (state == S_T6))          state_nxt = S_T1;
          else begin
            case (state)
              S_T1:    state_nxt = S_T2;
              S_T2:    state_nxt = S_T3;
              S_T3:    state_nxt = S_T4;
              S_T4:    state_nxt = S_T5;
              default: state_nxt = S_T6;
            endcase
          end
        end
      end
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    micro = '0;
    case (state)
      S_T1: begin micro.ep = 1'b1; micro.lm = 1'b1; end
      S_T2: micro.cp = 1'b1;
      S_T3: begin micro.ce = 1'b1; micro.li = 1'b1; end
      S_T4: begin
        case (instr_op)
          OP_LDA, OP_ADD, OP_SUB: begin micro.ei = 1'b1; micro.lm = 1'b1; end
          OP_JMP: begin micro.ei = 1'b1; micro.lp = 1'b1; end
          OP_JC:  begin micro.ei = carry_flag; micro.lp = carry_flag; end
          OP_JZ:  begin micro.ei = zero_flag;  micro.lp = zero_flag;  end
          OP_OUT: begin micro.ea = 1'b1; micro.lo = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        if (uses_alu_or_mem) micro.ce = 1'b1;
        if (instr_op == OP_LDA) micro.la = 1'b1;
        if ((instr_op == OP_ADD) || (instr_op == OP_SUB)) micro.lb = 1'b1;
      end
      S_T6: begin
        if ((instr_op == OP_ADD) || (instr_op == OP_SUB)) begin
          micro.eu = 1'b1;
          micro.la = 1'b1;
          micro.su = (instr_op == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // A frozen sequencer must not strobe any register, so run gates the whole word.
  assign ctrl = run ? micro : '0;

  assign {cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo} = ctrl;
  assign pc_clr_n = (state != S_INIT);
  assign hlt      = (state == S_HALT);

  always_comb begin
    t_state = '0;
    case (state)
      S_T1: t_state[0] = 1'b1;
      S_T2: t_state[1] = 1'b1;
      S_T3: t_state[2] = 1'b1;
      S_T4: t_state[3] = 1'b1;
      S_T5: t_state[4] = 1'b1;
      S_T6: t_state[5] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Self-checking bench for sap_controller_sequencer: directed literal checks plus random
// stimulus compared every cycle against a micro-op table model (honours SEQ_EARLY_RETIRE_EN).
module tb_sap_controller_sequencer;

  logic       clk = 1'b0;
  logic       clr, run, carry_flag, zero_flag;
  logic [3:0] instr_op;
  logic       pc_clr_n, cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt;
  logic [5:0] t_state;

  int errors = 0;
  int checks = 0;

  localparam logic [13:0] B_CP = 14'h2000, B_EP = 14'h1000, B_LP = 14'h0800, B_LM = 14'h0400;
  localparam logic [13:0] B_CE = 14'h0200, B_LI = 14'h0100, B_EI = 14'h0080, B_LA = 14'h0040;
  localparam logic [13:0] B_EA = 14'h0020, B_LB = 14'h0010, B_SU = 14'h0008, B_EU = 14'h0004;
  localparam logic [13:0] B_LO = 14'h0002, B_HLT = 14'h0001;

  sap_controller_sequencer #(.OP_W(4), .NUM_T(6)) dut (
    .clk(clk), .clr(clr), .run(run), .instr_op(instr_op),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_clr_n(pc_clr_n), .cp(cp), .ep(ep), .lp(lp), .lm(lm), .ce(ce), .li(li),
    .ei(ei), .la(la), .ea(ea), .lb(lb), .su(su), .eu(eu), .lo(lo), .hlt(hlt),
    .t_state(t_state)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ctl();
    return {cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt};
  endfunction

  // Micro-op table: control word of step k (1..6) for an opcode.
  function automatic logic [13:0] uop(int k, logic [3:0] op, logic c, logic z);
    logic [13:0] w;
    w = '0;
    case (k)
      1: w = B_EP | B_LM;
      2: w = B_CP;
      3: w = B_CE | B_LI;
      4: case (op)
           4'h0, 4'h1, 4'h2: w = B_EI | B_LM;
           4'h6: w = B_EI | B_LP;
           4'h7: w = c ? (B_EI | B_LP) : 14'h0;
           4'h8: w = z ? (B_EI | B_LP) : 14'h0;
           4'hE: w = B_EA | B_LO;
           default: w = '0;
         endcase
      5: case (op)
           4'h0: w = B_CE | B_LA;
           4'h1, 4'h2: w = B_CE | B_LB;
           default: w = '0;
         endcase
      6: case (op)
           4'h1: w = B_EU | B_LA;
           4'h2: w = B_EU | B_LA | B_SU;
           default: w = '0;
         endcase
      default: w = '0;
    endcase
    return w;
  endfunction

  // Number of steps an instruction occupies.
  function automatic int instr_len(logic [3:0] op, logic c, logic z);
    int last;
`ifdef SEQ_EARLY_RETIRE_EN
    last = 4;
    for (int k = 5; k <= 6; k++) if (uop(k, op, c, z) != 0) last = k;
`else
    last = 6;
`endif
    return last;
  endfunction

  // Behavioural model: init flag, halted flag and the current step number.
  bit m_init, m_halted;
  int m_step;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_init   <= 1'b1;
      m_halted <= 1'b0;
      m_step   <= 1;
    end else if (m_init) begin
      m_init <= 1'b0;
      m_step <= 1;
    end else if (!m_halted && run) begin
      if (m_step == 4 && instr_op == 4'hF)                      m_halted <= 1'b1;
      else if (m_step >= instr_len(instr_op, carry_flag, zero_flag)) m_step <= 1;
      else                                                      m_step <= m_step + 1;
    end
  end

  function automatic logic [20:0] model_out();
    if (clr || m_init) return '0;
    if (m_halted)      return {1'b1, B_HLT, 6'b0};
    return {1'b1, (run ? uop(m_step, instr_op, carry_flag, zero_flag) : 14'h0),
            6'(1 << (m_step - 1))};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("model", 32'({pc_clr_n, ctl(), t_state}), 32'(model_out()));
    check("bus_excl", 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
    check("cp_lp_excl", 32'(cp & lp), 32'd0);
  endtask

  task automatic to_t1();
    int n;
    n = 0;
    while (t_state != 6'b000001 && n < 10) begin
      tick();
      n++;
    end
    check("reach_T1", 32'(t_state), 32'h1);
  endtask

  localparam logic [13:0] ADD_SEQ [6] = '{B_EP | B_LM, B_CP, B_CE | B_LI,
                                          B_EI | B_LM, B_CE | B_LB, B_EU | B_LA};

  initial begin
    clr = 1'b0; run = 1'b1; instr_op = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
    #1 clr = 1'b1;

    // Reset and INIT
    repeat (3) tick();
    check("rst_pc_clr_n", 32'(pc_clr_n), 32'd0);
    check("rst_ctl", 32'(ctl()), 32'd0);
    check("rst_t", 32'(t_state), 32'd0);
    clr = 1'b0;
    #1 check("init_pc_clr_n", 32'(pc_clr_n), 32'd0);
    tick();
    check("t1_state", 32'(t_state), 32'h01);
    check("t1_ep_lm", 32'(ctl()), 32'(B_EP | B_LM));
    check("t1_pc_clr_n", 32'(pc_clr_n), 32'd1);

    // Full ADD sequence, back to T1 on the 7th edge
    instr_op = 4'h1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("add_T%0d", k + 1), 32'(ctl()), 32'(ADD_SEQ[k]));
      tick();
    end
    check("add_wrap", 32'(t_state), 32'h01);

    // JC taken and not taken
    for (int tk = 1; tk >= 0; tk--) begin
      instr_op = 4'h7;
      carry_flag = tk[0];
      repeat (3) tick();
      check("jc_t4_state", 32'(t_state), 32'h08);
      check("jc_t4_ctl", 32'(ctl()), tk[0] ? 32'(B_EI | B_LP) : 32'd0);
      tick();
`ifdef SEQ_EARLY_RETIRE_EN
      check("jc_after_t4", 32'(t_state), 32'h01);
`else
      check("jc_after_t4", 32'(t_state), 32'h10);
`endif
      to_t1();
    end
    carry_flag = 1'b0;

    // Freeze in T2
    instr_op = 4'h0;
    tick();
    check("frz_t2_cp", 32'(cp), 32'd1);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frz_cp", 32'(cp), 32'd0);
      check("frz_t", 32'(t_state), 32'h02);
    end
    run = 1'b1;
    #1 check("frz_resume_cp", 32'(cp), 32'd1);
    tick();
    check("frz_next_t3", 32'(t_state), 32'h04);
    check("frz_cp_once", 32'(cp), 32'd0);
    to_t1();

    // Halt
    instr_op = 4'hF;
    repeat (3) tick();
    check("hlt_t4", 32'(t_state), 32'h08);
    check("hlt_t4_hlt", 32'(hlt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hlt_word", 32'({pc_clr_n, ctl(), t_state}), 32'({1'b1, B_HLT, 6'b0}));
      run = $urandom_range(0, 1) == 1;
    end
    run = 1'b1;
    clr = 1'b1;
    #1 check("hlt_clr", 32'({pc_clr_n, ctl(), t_state}), 32'd0);
    tick();
    clr = 1'b0;
    #1 check("hlt_init", 32'(pc_clr_n), 32'd0);
    tick();
    check("hlt_exit_t1", 32'(t_state), 32'h01);

    // Async clear mid-SUB, between edges in T5
    instr_op = 4'h2;
    repeat (4) tick();
    check("sub_t5", 32'(ctl()), 32'(B_CE | B_LB));
    #2 clr = 1'b1;
    #1 check("async_clr", 32'({pc_clr_n, ctl(), t_state}), 32'd0);
    tick();
    clr = 1'b0;
    tick();
    check("async_t1", 32'(t_state), 32'h01);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      run        = $urandom_range(0, 7) != 0;
      instr_op   = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom);
      zero_flag  = 1'($urandom);
      clr        = $urandom_range(0, 59) == 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
